// File: rtl/ac_correlator_pkg.sv
// ============================================================================
// ac_correlator_pkg : shared constants and state encoding for the access-code correlator
// Rev 1.0
// ============================================================================
`default_nettype none

package ac_correlator_pkg;

   localparam int SW_LEN  = 64;
   localparam int SCORE_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_FOUND   = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/ac_correlator_popcount64.sv
// ============================================================================
// popcount64 : combinational ones count of a 64-bit vector
// Rev 1.0
// ============================================================================
`default_nettype none

module popcount64
   import ac_correlator_pkg::*;
(
   input  logic [63:0]        vec_i,
   output logic [SCORE_W-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < 64; i++) begin
         count_o = count_o + SCORE_W'(vec_i[i]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/ac_correlator.sv
// ============================================================================
// ac_correlator : sliding 64-bit sync-word correlator with search-window timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module ac_correlator #(
   parameter int SW_LEN = ac_correlator_pkg::SW_LEN,
   parameter int WIN_W  = 12
) (
   input  logic              clk_6M,
   input  logic              rst,
   input  logic              p_1us,
   input  logic              search_en,
   input  logic              rxbit,
   input  logic [SW_LEN-1:0] regi_syncword,
   input  logic [6:0]        regi_corr_thresh,
   input  logic [WIN_W-1:0]  regi_search_window,
   output logic              rx_trailer_st_p,
   output logic              corr_timeout_p,
   output logic              sync_found,
   output logic [6:0]        corr_score
);

   import ac_correlator_pkg::*;

   localparam logic [SCORE_W-1:0] FULL_FILL = SCORE_W'(SW_LEN);

   state_e              state_q;
   logic [SW_LEN-1:0]   sr_q;
   logic [SCORE_W-1:0]  fill_q;
   logic [SCORE_W-1:0]  score_q;
   logic [WIN_W-1:0]    win_q;
   logic                hit_q;
   logic                score_pend_q;
   logic [SCORE_W-1:0]  match_cnt;
   logic                strobe_in_search;

   popcount64 u_popcount (
      .vec_i   (~(sr_q ^ regi_syncword)),
      .count_o (match_cnt)
   );

   // Pulses are gated by search_en so an abort edge never emits a strobe.
   always_comb begin
      strobe_in_search = (state_q == ST_SEARCH) && search_en && p_1us && !rst;
      rx_trailer_st_p  = strobe_in_search && hit_q;
      corr_timeout_p   = strobe_in_search && !hit_q && (win_q == regi_search_window);
      sync_found       = (state_q == ST_FOUND);
      corr_score       = score_q;
   end

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sr_q         <= '0;
         fill_q       <= '0;
         score_q      <= '0;
         win_q        <= '0;
         hit_q        <= 1'b0;
         score_pend_q <= 1'b0;
      end else begin
         score_pend_q <= 1'b0;
         if (score_pend_q) begin
            score_q <= match_cnt;
            hit_q   <= (fill_q == FULL_FILL) && (match_cnt >= regi_corr_thresh);
         end

         if (!search_en) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_SEARCH;
                  fill_q  <= '0;
                  win_q   <= '0;
                  hit_q   <= 1'b0;
               end
               ST_SEARCH: begin
                  if (p_1us) begin
                     // Hit outranks window expiry; equality is tested before the increment.
                     if (hit_q) begin
                        state_q <= ST_FOUND;
                     end else if (win_q == regi_search_window) begin
                        state_q <= ST_TIMEOUT;
                     end else begin
                        sr_q         <= {sr_q[SW_LEN-2:0], rxbit};
                        win_q        <= win_q + WIN_W'(1);
                        score_pend_q <= 1'b1;
                        if (fill_q != FULL_FILL) begin
                           fill_q <= fill_q + SCORE_W'(1);
                        end
                     end
                  end
               end
               ST_FOUND:   ;
               ST_TIMEOUT: ;
               default:    state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ac_correlator.sv
// ============================================================================
// tb_ac_correlator : directed/random bench for ac_correlator with a bit-queue reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ac_correlator;

   logic        clk_6M = 1'b0;
   logic        rst = 1'b1;
   logic        p_1us = 1'b0;
   logic        search_en = 1'b0;
   logic        rxbit = 1'b0;
   logic [63:0] regi_syncword = '0;
   logic [6:0]  regi_corr_thresh = '0;
   logic [11:0] regi_search_window = '0;
   logic        rx_trailer_st_p;
   logic        corr_timeout_p;
   logic        sync_found;
   logic [6:0]  corr_score;

   localparam logic [63:0] SYNC = 64'hA5A5_0F0F_3C3C_F00F;
   localparam logic [63:0] ERR3 = 64'h0000_0100_0020_0001;

   ac_correlator dut (
      .clk_6M             (clk_6M),
      .rst                (rst),
      .p_1us              (p_1us),
      .search_en          (search_en),
      .rxbit              (rxbit),
      .regi_syncword      (regi_syncword),
      .regi_corr_thresh   (regi_corr_thresh),
      .regi_search_window (regi_search_window),
      .rx_trailer_st_p    (rx_trailer_st_p),
      .corr_timeout_p     (corr_timeout_p),
      .sync_found         (sync_found),
      .corr_score         (corr_score)
   );

   always #83 clk_6M = ~clk_6M;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: every bit ever shifted, plus search bookkeeping.
   bit q[$];
   int m_state;          // 0 idle, 1 search, 2 found, 3 timeout
   int m_win, m_fill, m_score, m_strobe;
   bit m_hit;
   int obs_tr, obs_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_score();
      int s = 0;
      for (int i = 0; i < 64; i++)
         if (q[q.size() - 64 + i] == regi_syncword[63 - i]) s++;
      return s;
   endfunction

   task automatic model_reset();
      q.delete();
      repeat (64) q.push_back(1'b0);
      m_state = 0; m_score = 0; m_hit = 1'b0;
      m_win = 0; m_fill = 0;
   endtask

   task automatic enter_check();
      if (!search_en) m_state = 0;
      else if (m_state == 0) begin
         m_state = 1; m_win = 0; m_fill = 0; m_hit = 1'b0;
         m_strobe = 0; obs_tr = 0; obs_to = 0;
      end
   endtask

   task automatic set_en(input logic v);
      @(negedge clk_6M); search_en = v;
      @(posedge clk_6M); enter_check();
      @(negedge clk_6M);
   endtask

   task automatic step(input logic b);
      logic etr, eto;
      etr = 1'b0; eto = 1'b0;
      if (m_state == 1) begin
         m_strobe++;
         if (m_hit) etr = 1'b1;
         else if (m_win == int'(regi_search_window)) eto = 1'b1;
      end
      @(negedge clk_6M); rxbit = b; p_1us = 1'b1; #1;
      if (rx_trailer_st_p === 1'b1) obs_tr = m_strobe;
      if (corr_timeout_p === 1'b1) obs_to = m_strobe;
      chk("trailer_p", rx_trailer_st_p, etr);
      chk("timeout_p", corr_timeout_p, eto);
      @(posedge clk_6M);
      if (etr) m_state = 2;
      else if (eto) m_state = 3;
      else if (m_state == 1) begin
         q.push_back(b);
         m_win++; m_fill++;
         m_score = model_score();
         m_hit = (m_fill >= 64) && (m_score >= int'(regi_corr_thresh));
      end
      @(negedge clk_6M); p_1us = 1'b0;
      @(negedge clk_6M);
      chk("corr_score", corr_score, m_score);
      chk("sync_found", sync_found, m_state == 2);
   endtask

   task automatic feed_rand(input int n);
      for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)));
   endtask

   task automatic feed_word(input logic [63:0] w, input logic [63:0] err);
      for (int i = 63; i >= 0; i--) step(w[i] ^ err[i]);
   endtask

   task automatic run_until(input int limit);
      for (int k = 0; k < limit && obs_tr == 0 && obs_to == 0; k++)
         step(1'($urandom_range(0, 1)));
   endtask

   task automatic do_reset();
      @(negedge clk_6M); rst = 1'b1;
      @(posedge clk_6M); model_reset();
      @(negedge clk_6M); rst = 1'b0; #1;
      chk("rst_sync_found", sync_found, 1'b0);
      chk("rst_corr_score", corr_score, 7'd0);
      chk("rst_trailer_p", rx_trailer_st_p, 1'b0);
      chk("rst_timeout_p", corr_timeout_p, 1'b0);
      @(posedge clk_6M); enter_check();
      @(negedge clk_6M);
   endtask

   task automatic search_case(input string tag, input logic [63:0] err, input logic [6:0] th,
                              input logic [11:0] win, input int exp_tr, input int exp_to);
      regi_corr_thresh = th; regi_search_window = win;
      set_en(1'b1);
      feed_rand(4);
      feed_word(SYNC, err);
      run_until(300);
      chk({tag, "_hit_strobe"}, obs_tr, exp_tr);
      chk({tag, "_timeout_strobe"}, obs_to, exp_to);
   endtask

   initial begin
      regi_syncword = SYNC;
      do_reset();

      // Exact match
      search_case("exact", 64'd0, 7'd64, 12'd200, 69, 0);
      chk("exact_score", corr_score, 7'd64);
      chk("exact_found", sync_found, 1'b1);
      set_en(1'b0);

      // Error tolerance
      search_case("err3_t61", ERR3, 7'd61, 12'd200, 69, 0);
      chk("err3_score", corr_score, 7'd61);
      set_en(1'b0);
      search_case("err3_t62", ERR3, 7'd62, 12'd200, 0, 201);
      set_en(1'b0);

      // Window boundary
      search_case("win67", 64'd0, 7'd64, 12'd67, 0, 68);
      set_en(1'b0);
      search_case("win68", 64'd0, 7'd64, 12'd68, 69, 0);
      set_en(1'b0);

      // Abort mid-search, then re-entry
      regi_corr_thresh = 7'd64; regi_search_window = 12'd200;
      set_en(1'b1);
      feed_rand(40);
      set_en(1'b0);
      feed_rand(3);
      chk("abort_no_hit", obs_tr, 0);
      chk("abort_no_timeout", obs_to, 0);
      chk("abort_idle_found", sync_found, 1'b0);
      set_en(1'b1);
      feed_word(SYNC, 64'd0);
      run_until(5);
      chk("reentry_hit_strobe", obs_tr, 65);

      // Reset while FOUND with search_en still high
      chk("pre_reset_found", sync_found, 1'b1);
      do_reset();
      feed_word(SYNC, 64'd0);
      run_until(5);
      chk("post_reset_hit_strobe", obs_tr, 65);
      set_en(1'b0);

      // Zero window, zero threshold
      regi_corr_thresh = 7'd64; regi_search_window = 12'd0;
      set_en(1'b1);
      run_until(5);
      chk("win0_timeout_strobe", obs_to, 1);
      chk("win0_no_hit", obs_tr, 0);
      set_en(1'b0);
      regi_corr_thresh = 7'd0; regi_search_window = 12'd100;
      set_en(1'b1);
      run_until(120);
      chk("th0_hit_strobe", obs_tr, 65);
      chk("th0_no_timeout", obs_to, 0);
      set_en(1'b0);

      // Threshold above 64 never hits
      search_case("th65", 64'd0, 7'd65, 12'd80, 0, 81);
      set_en(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
